inst_fetch: RTL

Instruction fetch stage directly upstream of the SPU decode/issue stage. It walks a pair-aligned program counter through instruction local store and prefetches 64-bit instruction pairs into a small queue. It presents one pair per cycle on `instOut` and holds it while decode signals `stallIn`. A branch redirect flushes all queued and in-flight fetches; a pair slot with nothing to issue carries the all-ones no-instruction marker that decode already recognises.

---
 rtl/spu_pkg.sv | 15 +
 rtl/inst_fetch_if.sv | 38 +++
 rtl/fetch_queue.sv | 42 ++++
 rtl/inst_fetch.sv | 126 ++++++++++++
 4 files changed

// File: rtl/spu_pkg.sv
// Constants and types shared by the SPU fetch and decode stages.
package spu_pkg;

  localparam int INST_WIDTH = 32;
  localparam logic [INST_WIDTH-1:0] NOP_INST = 32'hFFFF_FFFF;
  localparam logic [2*INST_WIDTH-1:0] EMPTY_PAIR = {NOP_INST, NOP_INST};

  typedef logic [2*INST_WIDTH-1:0] inst_pair_t;

  // Event counters stick at all-ones instead of wrapping.
  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/inst_fetch_if.sv
// Fetch-stage bus: decode handshake, redirect, local-store port, output pair.
// Perf counter outputs exist only when INST_FETCH_PERF_EN is defined.
interface inst_fetch_if
  import spu_pkg::*;
#(
  parameter int pcWidth   = 11,
  parameter int instWidth = INST_WIDTH
);
  logic                     stallIn;
  logic                     branchTaken;
  logic [pcWidth:0]         branchTarget;
  logic                     memReq;
  logic [pcWidth-1:0]       memAddr;
  logic [2*instWidth-1:0]   memData;
  logic [2*instWidth-1:0]   instOut;
  logic                     instValid;
`ifdef INST_FETCH_PERF_EN
  logic [31:0]              perfPairs;
  logic [31:0]              perfStalls;
  logic [31:0]              perfRedirects;
`endif

  modport master (
    input  stallIn, branchTaken, branchTarget, memData,
    output memReq, memAddr, instOut, instValid
`ifdef INST_FETCH_PERF_EN
    , output perfPairs, perfStalls, perfRedirects
`endif
  );

  modport slave (
    output stallIn, branchTaken, branchTarget, memData,
    input  memReq, memAddr, instOut, instValid
`ifdef INST_FETCH_PERF_EN
    , input perfPairs, perfStalls, perfRedirects
`endif
  );
endinterface

// File: rtl/fetch_queue.sv
// Small power-of-two FIFO holding prefetched instruction pairs; flush beats push/pop.
module fetch_queue #(
  parameter int  DEPTH = 4,
  parameter int  WIDTH = 64,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = AW + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] push_data_i,
  input  logic             pop_i,
  output logic [CW-1:0]    count_o,
  output logic [WIDTH-1:0] head_o
);
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]    count_q;
  logic             do_push, do_pop;

  assign do_pop  = pop_i && (count_q != '0);
  assign do_push = push_i && ((count_q != CW'(DEPTH)) || do_pop);

  always_ff @(posedge clk) begin
    if (!reset || flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q] <= push_data_i;
        wr_ptr_q        <= wr_ptr_q + AW'(1);
      end
      if (do_pop) rd_ptr_q <= rd_ptr_q + AW'(1);
      count_q <= count_q + CW'(do_push) - CW'(do_pop);
    end
  end

  assign count_o = count_q;
  assign head_o  = mem_q[rd_ptr_q];
endmodule

// File: rtl/inst_fetch.sv
// SPU instruction fetch: pair-aligned PC, 2-deep memory pipeline, prefetch queue.
// Define INST_FETCH_PERF_EN to add saturating pop/stall/redirect counters.
module inst_fetch
  import spu_pkg::*;
#(
  parameter int pcWidth   = 11,
  parameter int depth     = 4,
  parameter int instWidth = INST_WIDTH
) (
  input logic          clk,
  input logic          reset,
  inst_fetch_if.master bus
);
  localparam int CntW = $clog2(depth) + 1;
  typedef logic [2*instWidth-1:0] pair_t;

  logic [pcWidth-1:0] pc_q, pc_d;
  logic               mem_req_q, mem_req_d;
  logic [pcWidth-1:0] mem_addr_q, mem_addr_d;
  logic               resp_q, resp_d;
  logic               odd_q, odd_d;
  pair_t              inst_q, inst_d;
  logic               valid_q, valid_d;

  logic [CntW-1:0]    q_count;
  pair_t              q_head, push_data;
  logic               push, pop;
  logic [1:0]         in_flight;
  logic               can_issue;

  fetch_queue #(.DEPTH(depth), .WIDTH(2*instWidth)) u_queue (
    .clk        (clk),
    .reset      (reset),
    .flush_i    (bus.branchTaken),
    .push_i     (push),
    .push_data_i(push_data),
    .pop_i      (pop),
    .count_o    (q_count),
    .head_o     (q_head)
  );

  always_comb begin
    // resp_q marks a response whose data must be sampled at the coming edge.
    in_flight  = 2'(mem_req_q) + 2'(resp_q);
    can_issue  = (int'(q_count) + int'(in_flight)) < depth;
    push       = resp_q && !bus.branchTaken;
    push_data  = bus.memData;
    if (odd_q) push_data[instWidth-1:0] = '1;
    pop        = 1'b0;
    pc_d       = pc_q;
    mem_req_d  = 1'b0;
    mem_addr_d = mem_addr_q;
    resp_d     = mem_req_q && !bus.branchTaken;
    odd_d      = odd_q && !push;
    inst_d     = inst_q;
    valid_d    = valid_q;

    if (bus.branchTaken) begin
      pc_d    = bus.branchTarget[pcWidth:1];
      odd_d   = bus.branchTarget[0];
      inst_d  = '1;
      valid_d = 1'b0;
    end else begin
      if (can_issue) begin
        mem_req_d  = 1'b1;
        mem_addr_d = pc_q;
        pc_d       = pc_q + pcWidth'(1);
      end
      if (!bus.stallIn) begin
        if (q_count != '0) begin
          inst_d  = q_head;
          valid_d = 1'b1;
          pop     = 1'b1;
        end else begin
          inst_d  = '1;
          valid_d = 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      pc_q       <= '0;
      mem_req_q  <= 1'b0;
      mem_addr_q <= '0;
      resp_q     <= 1'b0;
      odd_q      <= 1'b0;
      inst_q     <= '1;
      valid_q    <= 1'b0;
    end else begin
      pc_q       <= pc_d;
      mem_req_q  <= mem_req_d;
      mem_addr_q <= mem_addr_d;
      resp_q     <= resp_d;
      odd_q      <= odd_d;
      inst_q     <= inst_d;
      valid_q    <= valid_d;
    end
  end

  assign bus.memReq    = mem_req_q;
  assign bus.memAddr   = mem_addr_q;
  assign bus.instOut   = inst_q;
  assign bus.instValid = valid_q;

`ifdef INST_FETCH_PERF_EN
  logic [31:0] perf_pairs_q, perf_stalls_q, perf_redirects_q;

  always_ff @(posedge clk) begin
    if (!reset) begin
      perf_pairs_q     <= '0;
      perf_stalls_q    <= '0;
      perf_redirects_q <= '0;
    end else begin
      if (pop)             perf_pairs_q     <= sat_inc(perf_pairs_q);
      if (bus.stallIn)     perf_stalls_q    <= sat_inc(perf_stalls_q);
      if (bus.branchTaken) perf_redirects_q <= sat_inc(perf_redirects_q);
    end
  end

  assign bus.perfPairs     = perf_pairs_q;
  assign bus.perfStalls    = perf_stalls_q;
  assign bus.perfRedirects = perf_redirects_q;
`endif
endmodule
